line_collector: RTL and testbench
=================================

LINE_COLLECTOR -- requirements
Module: line_collector

Interface
REQ-001 Parameter LINE_W, default 25, SHALL set bits per line (one bit per lane).
REQ-002 Parameter NUM_LINES, default 64, SHALL set lines per state, equal to the lane width.
REQ-003 clk  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-low reset.
REQ-005 start  in  1  SHALL begin a new collection.
REQ-006 in_valid  in  1  SHALL indicate in_line holds a line.
REQ-007 in_ready  out  1  SHALL indicate a line can be accepted this cycle.
REQ-008 in_line  in  LINE_W  SHALL carry the line; bit m belongs to lane m.
REQ-009 in_idx  in  6  SHALL carry the sender's line number.
REQ-010 full  out  1  SHALL be high when all NUM_LINES lines are held.
REQ-011 count  out  7  SHALL give the number of lines accepted, 0..64.
REQ-012 lane_req  in  1  SHALL request a lane readout.
REQ-013 lane_sel  in  5  SHALL select the lane, 0..24.
REQ-014 lane_valid  out  1  SHALL mark valid lane_data.
REQ-015 lane_data  out  64  SHALL carry the selected lane; bit n comes from line n.
REQ-016 err  out  1  SHALL be a sticky line-order error flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, COLLECT and FULL.
REQ-018 From IDLE or FULL, start=1 SHALL enter COLLECT next cycle with count=0 and full=0.
REQ-019 in_ready SHALL be 1 only in COLLECT.
REQ-020 An accept SHALL occur when in_valid and in_ready are both 1 and start=0.
- The accept writes in_line into the line at address count[5:0].
- count increments on the same edge.
REQ-021 The accept that makes count=64 SHALL move to FULL, so full=1 on the following cycle.
REQ-022 start=1 in COLLECT SHALL restart with count=0; a line presented in the same cycle SHALL be discarded.
REQ-023 In FULL, lane_req=1 with lane_sel<25 SHALL give lane_valid=1 exactly one cycle later, with lane_data[n]=line[n][lane_sel] for all n.
REQ-024 lane_req with lane_sel>=25, or lane_req outside FULL, SHALL be ignored: lane_valid=0 and lane_data unchanged.
REQ-025 lane_valid SHALL be a one-cycle pulse per request; back-to-back requests SHALL give back-to-back responses.
REQ-026 start arriving with a pending request SHALL still deliver the response on the next cycle, from pre-restart contents.
REQ-027 Line storage SHALL NOT be cleared by start; lines are overwritten only by accepts.

Reset
REQ-028 rst=0 SHALL force the following on the next edge, regardless of state or mid-collection:
- state IDLE
- count 0, full 0, in_ready 0
- lane_valid 0, lane_data 0, err 0
REQ-029 Line storage contents SHALL NOT be reset.

Configuration
REQ-030 With IDX_CHECK_EN defined, each accept with in_idx != count[5:0] SHALL set err.
- err stays set until start or reset.
- The line is still stored at count.
REQ-031 Without IDX_CHECK_EN, err SHALL be tied 0 and in_idx SHALL be ignored.

Structure
REQ-032 Package state_pkg SHALL hold the shared definitions:
- constants LINE_W=25, NUM_LINES=64, NUM_LANES=25, LANE_W=64
- the FSM state enum
REQ-033 Sub-module line_mem SHALL hold the 64x25 register array with one write port and a transposed, registered lane read port.

Verification
REQ-034 Reset, start, 64 lines with line i = i replicated to 25 bits -> full=1 the cycle after the 64th accept, count=64, in_ready=0.
REQ-035 In FULL, lane_req with lane_sel=0, then 24 on consecutive cycles -> two lane_valid pulses; lane_data equals bit 0, then bit 24, of lines 0..63.
REQ-036 Load 10 lines, then start with in_valid=1 -> that line is dropped and count=0; a 64-line reload then reads back only the new data.
REQ-037 rst=0 at count=30 -> IDLE, count=0, in_ready=0; lane_req is then ignored (lane_valid=0).
REQ-038 IDX_CHECK_EN defined, in_idx=5 sent at count=3 -> err=1 next cycle and held until start; undefined -> err=0 throughout.
REQ-039 lane_req with lane_sel=25 in FULL -> lane_valid stays 0.

Source files
------------

// File: rtl/state_pkg.sv
// Shared definitions for the line collector: geometry constants, port widths and FSM states.
package state_pkg;

    localparam int unsigned LINE_W    = 25;
    localparam int unsigned NUM_LINES = 64;
    localparam int unsigned NUM_LANES = 25;
    localparam int unsigned LANE_W    = 64;

    localparam int unsigned IDX_W = 6;  // line address / sender line number
    localparam int unsigned CNT_W = 7;  // line count, 0..64
    localparam int unsigned SEL_W = 5;  // lane select, 0..24 valid

    typedef enum logic [1:0] {
        s_idle    = 2'd0,
        s_collect = 2'd1,
        s_full    = 2'd2
    } state_t;

endpackage

// File: rtl/line_mem.sv
// Line storage: NUM_LINES x LINE_W register array with one line write port and a
// transposed read port that returns one lane (one bit of every line), registered.
// Storage is never reset; only the read-port output registers are.
module line_mem
    import state_pkg::*;
#(
    parameter int unsigned LINE_W    = state_pkg::LINE_W,
    parameter int unsigned NUM_LINES = state_pkg::NUM_LINES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [LINE_W-1:0]    wdata,
    input  logic                 rd_en,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic                 rd_valid,
    output logic [NUM_LINES-1:0] rd_data
);

    logic [LINE_W-1:0]    mem_q [NUM_LINES];
    logic [NUM_LINES-1:0] lane_d;

    // Line write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Gather the selected bit of every line into one lane word.
    always_comb begin
        lane_d = '0;
        for (int n = 0; n < int'(NUM_LINES); n++) begin
            lane_d[n] = mem_q[n][rd_sel];
        end
    end

    // Registered lane response; data holds its value between requests.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= lane_d;
            end
        end
    end

endmodule

// File: rtl/line_collector.sv
// Line collector: accepts NUM_LINES lines in order, then serves transposed lane readouts.
// Optional feature: define IDX_CHECK_EN to flag (sticky err) accepts whose in_idx does not
// match the current line count.
module line_collector
    import state_pkg::*;
#(
    parameter int unsigned LINE_W    = state_pkg::LINE_W,
    parameter int unsigned NUM_LINES = state_pkg::NUM_LINES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LINE_W-1:0]    in_line,
    input  logic [IDX_W-1:0]     in_idx,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    input  logic                 lane_req,
    input  logic [SEL_W-1:0]     lane_sel,
    output logic                 lane_valid,
    output logic [NUM_LINES-1:0] lane_data,
    output logic                 err
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic             rd_en;

    assign in_ready = (state_q == s_collect);
    assign full     = (state_q == s_full);
    assign count    = count_q;
    // start wins over a line presented in the same cycle.
    assign accept   = in_valid && in_ready && !start;
    // Only in FULL and only for an existing lane; otherwise the request is dropped.
    assign rd_en    = (state_q == s_full) && lane_req && (lane_sel < SEL_W'(NUM_LANES));

    // State and line count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= s_idle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and count logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            s_idle: begin
                if (start) begin
                    state_d = s_collect;
                    count_d = '0;
                end
            end
            s_collect: begin
                if (start) begin
                    count_d = '0;
                end else if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(NUM_LINES - 1)) begin
                        state_d = s_full;
                    end
                end
            end
            s_full: begin
                if (start) begin
                    state_d = s_collect;
                    count_d = '0;
                end
            end
            default: begin
                state_d = s_idle;
                count_d = '0;
            end
        endcase
    end

`ifdef IDX_CHECK_EN
    logic err_q, err_d;

    // Sticky index mismatch flag, cleared by start.
    always_comb begin
        err_d = err_q;
        if (start) begin
            err_d = 1'b0;
        end else if (accept && (in_idx != count_q[IDX_W-1:0])) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_idx;
    assign unused_idx = ^in_idx;
    assign err        = 1'b0;
`endif

    line_mem #(
        .LINE_W    (LINE_W),
        .NUM_LINES (NUM_LINES)
    ) u_line_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (accept),
        .waddr    (count_q[IDX_W-1:0]),
        .wdata    (in_line),
        .rd_en    (rd_en),
        .rd_sel   (lane_sel),
        .rd_valid (lane_valid),
        .rd_data  (lane_data)
    );

endmodule

// File: tb/tb_line_collector.sv
// Self-checking bench for line_collector: directed scenarios followed by random traffic,
// all compared every cycle against a behavioural model of the collector.
module tb_line_collector;

    localparam int NL = 64;
    localparam int LW = 25;
    localparam int NLANE = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_line;
    logic [5:0]    in_idx;
    logic          full;
    logic [6:0]    count;
    logic          lane_req;
    logic [4:0]    lane_sel;
    logic          lane_valid;
    logic [NL-1:0] lane_data;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 = idle, 1 = collecting, 2 = full.
    int            m_phase;
    int            m_count;
    logic [LW-1:0] m_lines [NL];
    bit            m_err;
    bit            m_lvalid;
    logic [NL-1:0] m_ldata;

    always #5 clk = ~clk;

    line_collector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_line    (in_line),
        .in_idx     (in_idx),
        .full       (full),
        .count      (count),
        .lane_req   (lane_req),
        .lane_sel   (lane_sel),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .err        (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules of the collector to the inputs seen at this edge.
    task automatic model_step();
        if (!rst) begin
            m_phase  = 0;
            m_count  = 0;
            m_err    = 0;
            m_lvalid = 0;
            m_ldata  = '0;
            return;
        end
        // Lane read uses contents from before this edge.
        if (m_phase == 2 && lane_req && int'(lane_sel) < NLANE) begin
            m_lvalid = 1;
            for (int n = 0; n < NL; n++) m_ldata[n] = m_lines[n][lane_sel];
        end else begin
            m_lvalid = 0;
        end
        if (start) begin
            m_phase = 1;
            m_count = 0;
            m_err   = 0;
        end else if (m_phase == 1 && in_valid) begin
            m_lines[m_count] = in_line;
`ifdef IDX_CHECK_EN
            if (int'(in_idx) != m_count) m_err = 1;
`endif
            m_count++;
            if (m_count == NL) m_phase = 2;
        end
    endtask

    task automatic check_outputs();
        check("count", 64'(count), 64'(m_count));
        check("full", 64'(full), 64'(m_phase == 2));
        check("in_ready", 64'(in_ready), 64'(m_phase == 1));
        check("lane_valid", 64'(lane_valid), 64'(m_lvalid));
        check("lane_data", lane_data, m_ldata);
        check("err", 64'(err), 64'(m_err));
    endtask

    // One clock: inputs held across the edge, model stepped, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_line  = '0;
        in_idx   = '0;
        lane_req = 1'b0;
        lane_sel = '0;
    endtask

    task automatic send_line(input logic [LW-1:0] l);
        in_valid = 1'b1;
        in_line  = l;
        in_idx   = 6'(m_count);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic lane_read(input int sel);
        lane_req = 1'b1;
        lane_sel = 5'(sel);
        cyc();
        lane_req = 1'b0;
    endtask

    initial begin
        logic [5:0]    iv;
        logic [NL-1:0] exp_lane;
        for (int i = 0; i < NL; i++) m_lines[i] = 'x;
        m_phase = 0; m_count = 0; m_err = 0; m_lvalid = 0; m_ldata = '0;

        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Full load with line i = i replicated.
        do_start();
        for (int i = 0; i < NL; i++) begin
            iv = 6'(i);
            send_line({iv[0], iv, iv, iv, iv});
        end
        check("full_after_64", 64'(full), 64'd1);
        check("count_64", 64'(count), 64'd64);

        // Lanes 0 and 24 back-to-back.
        lane_req = 1'b1;
        lane_sel = 5'd0;
        cyc();
        for (int n = 0; n < NL; n++) exp_lane[n] = 1'(n);
        check("lane0_pulse", 64'(lane_valid), 64'd1);
        check("lane0_data", lane_data, exp_lane);
        lane_sel = 5'd24;
        cyc();
        lane_req = 1'b0;
        for (int n = 0; n < NL; n++) exp_lane[n] = 1'(n);
        check("lane24_pulse", 64'(lane_valid), 64'd1);
        check("lane24_data", lane_data, exp_lane);
        cyc();
        check("lane_pulse_end", 64'(lane_valid), 64'd0);

        // Out-of-range lane ignored.
        lane_read(25);
        check("lane25_ignored", 64'(lane_valid), 64'd0);
        lane_read(31);

        // Request pending when start arrives still answers from old contents.
        lane_req = 1'b1;
        lane_sel = 5'd1;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
        lane_req = 1'b0;
        for (int n = 0; n < NL; n++) exp_lane[n] = 1'(n >> 1);
        check("req_at_start_data", lane_data, exp_lane);

        // 10 lines, then start with a line present: line dropped.
        for (int i = 0; i < 10; i++) send_line(LW'($urandom));
        in_valid = 1'b1;
        in_line  = LW'($urandom);
        start    = 1'b1;
        cyc();
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_drops_line", 64'(count), 64'd0);
        for (int i = 0; i < NL; i++) send_line(LW'($urandom));
        for (int s = 0; s < NLANE; s++) lane_read(s);
        lane_read(int'($urandom_range(0, 24)));

        // Index mismatch at count 3.
        do_start();
        for (int i = 0; i < 3; i++) send_line(LW'($urandom));
        in_valid = 1'b1;
        in_line  = LW'($urandom);
        in_idx   = 6'd5;
        cyc();
        in_valid = 1'b0;
`ifdef IDX_CHECK_EN
        check("idx_err_set", 64'(err), 64'd1);
`else
        check("idx_err_off", 64'(err), 64'd0);
`endif
        cyc();
        do_start();
        check("err_clr_start", 64'(err), 64'd0);

        // Reset mid-collection at count 30.
        for (int i = 0; i < 30; i++) send_line(LW'($urandom));
        check("count_30", 64'(count), 64'd30);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        lane_read(2);
        check("lane_after_rst", 64'(lane_valid), 64'd0);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            rst      = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 79) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_line  = LW'($urandom);
            in_idx   = ($urandom_range(0, 19) == 0) ? 6'($urandom) : 6'(m_count);
            lane_req = ($urandom_range(0, 1) == 1);
            lane_sel = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31))
                                                   : 5'($urandom_range(0, 24));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
